trap_dump_unit: RTL and testbench

Hardware counterpart to the simulation-only end-of-program memory dump. It watches the single-cycle core's fetched instruction for the terminating trap (0x44000300) and halts the core. It then reads a fixed window of DMEM as big-endian 32-bit words and streams each word out over a valid/ready interface. It sits beside `singlecycle`, sharing the DMEM read port with the datapath while halted.

---
 rtl/sc_pkg.sv | 15 +
 rtl/trap_dump_unit_if.sv | 23 ++
 rtl/trap_dump_unit.sv | 123 ++++++++++++
 tb/tb_trap_dump_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// Shared definitions for the single-cycle core and its end-of-program dump engine.
package sc_pkg;

  typedef enum logic [1:0] {
    RUN,
    FETCH,
    SEND,
    DONE
  } dump_state_e;

  localparam logic [31:0] TRAP_HALT  = 32'h44000300;
  localparam int unsigned DUMP_BASE  = 8192;
  localparam int unsigned DUMP_WORDS = 10;

endpackage

// File: rtl/trap_dump_unit_if.sv
// Valid/ready stream carrying dumped (address, word) pairs out of the dump engine.
interface trap_dump_unit_if;

  logic        out_valid;
  logic        out_ready;
  logic [0:31] out_addr;
  logic [0:31] out_data;

  modport master (
    output out_valid,
    output out_addr,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_addr,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/trap_dump_unit.sv
// Halts the core on the terminating trap, then streams a fixed DMEM window out
// as big-endian words over a valid/ready channel.
module trap_dump_unit
  import sc_pkg::*;
#(
  parameter logic [31:0] TRAP_WORD = TRAP_HALT,
  parameter int unsigned BASE_ADDR = DUMP_BASE,
  parameter int unsigned NUM_WORDS = DUMP_WORDS
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [0:31]             instruction,
  output logic                    halt,
  output logic [0:31]             dmem_addr,
  output logic                    dmem_rd_en,
  input  logic [0:31]             dmem_rdata,
  trap_dump_unit_if.master        out_if,
  output logic                    done
);

  localparam int IDX_W = $clog2(NUM_WORDS) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  dump_state_e      state_q,      state_d;
  logic [IDX_W-1:0] idx_q,        idx_d;
  logic [0:31]      dmem_addr_q,  dmem_addr_d;
  logic             dmem_rd_en_q, dmem_rd_en_d;
  logic             out_valid_q,  out_valid_d;
  logic [0:31]      out_addr_q,   out_addr_d;
  logic [0:31]      out_data_q,   out_data_d;
  logic             done_q,       done_d;

  logic trap_hit;

  // Window address wraps modulo 2^32; the parameters are trusted to keep it in range.
  function automatic logic [31:0] word_addr(input logic [IDX_W-1:0] i);
    return 32'(BASE_ADDR) + (32'(i) << 2);
  endfunction

  assign trap_hit = (instruction == TRAP_WORD);

  // Halt is combinational in RUN so the PC never advances past the trap.
  assign halt = (state_q == RUN) ? trap_hit : 1'b1;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_rd_en_d = dmem_rd_en_q;
    out_valid_d  = out_valid_q;
    out_addr_d   = out_addr_q;
    out_data_d   = out_data_q;
    done_d       = done_q;

    case (state_q)
      RUN: begin
        if (trap_hit) begin
          state_d      = FETCH;
          idx_d        = '0;
          dmem_addr_d  = word_addr('0);
          dmem_rd_en_d = 1'b1;
        end
      end
      FETCH: begin
        out_data_d   = dmem_rdata;
        out_addr_d   = dmem_addr_q;
        out_valid_d  = 1'b1;
        dmem_rd_en_d = 1'b0;
        state_d      = SEND;
      end
      SEND: begin
        if (out_valid_q && out_if.out_ready) begin
          out_valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            idx_d        = idx_q + IDX_W'(1);
            dmem_addr_d  = word_addr(idx_q + IDX_W'(1));
            dmem_rd_en_d = 1'b1;
            state_d      = FETCH;
          end
        end
      end
      DONE: begin
        done_d = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= RUN;
      idx_q        <= '0;
      dmem_addr_q  <= '0;
      dmem_rd_en_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_addr_q   <= '0;
      out_data_q   <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_rd_en_q <= dmem_rd_en_d;
      out_valid_q  <= out_valid_d;
      out_addr_q   <= out_addr_d;
      out_data_q   <= out_data_d;
      done_q       <= done_d;
    end
  end

  assign dmem_addr        = dmem_addr_q;
  assign dmem_rd_en       = dmem_rd_en_q;
  assign out_if.out_valid = out_valid_q;
  assign out_if.out_addr  = out_addr_q;
  assign out_if.out_data  = out_data_q;
  assign done             = done_q;

endmodule

// File: tb/tb_trap_dump_unit.sv
// Directed bench for trap_dump_unit: default 10-word window plus a 1-word instance at address 0.
module tb_trap_dump_unit;

  localparam logic [31:0] TRAP = 32'h44000300;

  logic        clock;
  logic        reset;
  logic [0:31] instr0, instr1;
  logic        halt0, halt1;
  logic [0:31] dmem_addr0, dmem_addr1;
  logic        rd_en0, rd_en1;
  logic [0:31] rdata0, rdata1;
  logic        done0, done1;

  int checks;
  int failures;

  logic [7:0] mem [0:16383];

  trap_dump_unit_if if0 ();
  trap_dump_unit_if if1 ();

  trap_dump_unit u0 (
    .clock(clock), .reset(reset), .instruction(instr0), .halt(halt0),
    .dmem_addr(dmem_addr0), .dmem_rd_en(rd_en0), .dmem_rdata(rdata0),
    .out_if(if0), .done(done0)
  );

  trap_dump_unit #(.TRAP_WORD(32'h44000300), .BASE_ADDR(0), .NUM_WORDS(1)) u1 (
    .clock(clock), .reset(reset), .instruction(instr1), .halt(halt1),
    .dmem_addr(dmem_addr1), .dmem_rd_en(rd_en1), .dmem_rdata(rdata1),
    .out_if(if1), .done(done1)
  );

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    logic [13:0] b;
    b = a[13:0];
    return {mem[b], mem[b + 14'd1], mem[b + 14'd2], mem[b + 14'd3]};
  endfunction

  assign rdata0 = rd_word(dmem_addr0);
  assign rdata1 = rd_word(dmem_addr1);

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    instr0 = '0;
    instr1 = '0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    instr0 = TRAP;
    if0.out_ready = 1'b1;
    tick();
    tick();
    checks++; if (if0.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", if0.out_valid); end
    checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done0); end
    checks++; if (rd_en0 !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%0b exp=0", rd_en0); end
    checks++; if (if0.out_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%08h exp=0", if0.out_data); end
    checks++; if (if0.out_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%08h exp=0", if0.out_addr); end
    checks++; if (dmem_addr0 !== 32'h0) begin failures++; $display("FAIL reset_dmem_addr got=%08h exp=0", dmem_addr0); end
    checks++; if (halt0 !== 1'b1) begin failures++; $display("FAIL reset_halt_trap got=%0b exp=1", halt0); end
    instr0 = '0;
    #1;
    checks++; if (halt0 !== 1'b0) begin failures++; $display("FAIL reset_halt_idle got=%0b exp=0", halt0); end
    reset = 1'b1;
  endtask

  task automatic test_full_dump();
    do_reset();
    if0.out_ready = 1'b1;
    instr0 = TRAP;
    #1;
    checks++; if (halt0 !== 1'b1) begin failures++; $display("FAIL full_halt_T got=%0b exp=1", halt0); end
    tick();
    instr0 = '0;
    #1;
    checks++; if (rd_en0 !== 1'b1) begin failures++; $display("FAIL full_fetch_rd_en got=%0b exp=1", rd_en0); end
    checks++; if (dmem_addr0 !== 32'h2000) begin failures++; $display("FAIL full_fetch_addr got=%08h exp=00002000", dmem_addr0); end
    checks++; if (halt0 !== 1'b1) begin failures++; $display("FAIL full_halt_fetch got=%0b exp=1", halt0); end
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++; if (if0.out_valid !== 1'b1) begin failures++; $display("FAIL full_valid k=%0d got=%0b exp=1", k, if0.out_valid); end
      checks++; if (if0.out_addr !== 32'h2000 + 32'(4 * k)) begin failures++; $display("FAIL full_addr k=%0d got=%08h exp=%08h", k, if0.out_addr, 32'h2000 + 32'(4 * k)); end
      checks++; if (if0.out_data !== 32'(k + 1)) begin failures++; $display("FAIL full_data k=%0d got=%08h exp=%08h", k, if0.out_data, 32'(k + 1)); end
      checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL full_early_done k=%0d got=%0b exp=0", k, done0); end
      tick();
      if (k < 9) begin
        checks++; if (rd_en0 !== 1'b1 || if0.out_valid !== 1'b0) begin failures++; $display("FAIL full_refetch k=%0d rd_en=%0b valid=%0b exp=1/0", k, rd_en0, if0.out_valid); end
        checks++; if (dmem_addr0 !== 32'h2000 + 32'(4 * (k + 1))) begin failures++; $display("FAIL full_dmem_addr k=%0d got=%08h exp=%08h", k, dmem_addr0, 32'h2000 + 32'(4 * (k + 1))); end
      end else begin
        checks++; if (done0 !== 1'b1) begin failures++; $display("FAIL full_done got=%0b exp=1", done0); end
        checks++; if (if0.out_valid !== 1'b0 || halt0 !== 1'b1) begin failures++; $display("FAIL full_done_state valid=%0b halt=%0b exp=0/1", if0.out_valid, halt0); end
      end
    end
  endtask

  task automatic test_backpressure();
    int words;
    words = 0;
    do_reset();
    if0.out_ready = 1'b1;
    instr0 = TRAP;
    tick();
    instr0 = '0;
    tick();
    for (int k = 0; k < 10; k++) begin
      checks++; if (if0.out_valid !== 1'b1 || if0.out_addr !== 32'h2000 + 32'(4 * k)) begin failures++; $display("FAIL bp_word k=%0d valid=%0b addr=%08h exp_addr=%08h", k, if0.out_valid, if0.out_addr, 32'h2000 + 32'(4 * k)); end
      checks++; if (if0.out_data !== 32'(k + 1)) begin failures++; $display("FAIL bp_data k=%0d got=%08h exp=%08h", k, if0.out_data, 32'(k + 1)); end
      if (k == 2) begin
        if0.out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          checks++; if (if0.out_valid !== 1'b1 || if0.out_addr !== 32'h2008 || if0.out_data !== 32'd3) begin failures++; $display("FAIL bp_hold s=%0d valid=%0b addr=%08h data=%08h exp=1/00002008/00000003", s, if0.out_valid, if0.out_addr, if0.out_data); end
        end
        if0.out_ready = 1'b1;
      end
      words++;
      tick();
      tick();
    end
    checks++; if (words !== 10 || done0 !== 1'b1) begin failures++; $display("FAIL bp_total words=%0d done=%0b exp=10/1", words, done0); end
  endtask

  task automatic test_non_match();
    do_reset();
    if0.out_ready = 1'b0;
    instr0 = 32'h44000301;
    #1;
    checks++; if (halt0 !== 1'b0) begin failures++; $display("FAIL nm_halt got=%0b exp=0", halt0); end
    tick();
    checks++; if (rd_en0 !== 1'b0 || if0.out_valid !== 1'b0) begin failures++; $display("FAIL nm_no_start rd_en=%0b valid=%0b exp=0/0", rd_en0, if0.out_valid); end
    instr0 = TRAP;
    tick();
    instr0 = '0;
    tick();
    instr0 = TRAP;
    checks++; if (if0.out_valid !== 1'b1 || if0.out_addr !== 32'h2000) begin failures++; $display("FAIL nm_send valid=%0b addr=%08h exp=1/00002000", if0.out_valid, if0.out_addr); end
    tick();
    checks++; if (if0.out_valid !== 1'b1 || if0.out_addr !== 32'h2000 || rd_en0 !== 1'b0) begin failures++; $display("FAIL nm_trap_in_send valid=%0b addr=%08h rd_en=%0b exp=1/00002000/0", if0.out_valid, if0.out_addr, rd_en0); end
    if0.out_ready = 1'b1;
    tick();
    checks++; if (rd_en0 !== 1'b1 || dmem_addr0 !== 32'h2004) begin failures++; $display("FAIL nm_next_fetch rd_en=%0b addr=%08h exp=1/00002004", rd_en0, dmem_addr0); end
    tick();
    checks++; if (if0.out_addr !== 32'h2004 || if0.out_data !== 32'd2) begin failures++; $display("FAIL nm_next_word addr=%08h data=%08h exp=00002004/00000002", if0.out_addr, if0.out_data); end
    instr0 = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    if0.out_ready = 1'b1;
    instr0 = TRAP;
    tick();
    instr0 = '0;
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      tick();
    end
    if0.out_ready = 1'b0;
    checks++; if (if0.out_valid !== 1'b1 || if0.out_addr !== 32'h200C) begin failures++; $display("FAIL mid_word4 valid=%0b addr=%08h exp=1/0000200c", if0.out_valid, if0.out_addr); end
    reset = 1'b0;
    tick();
    checks++; if (if0.out_valid !== 1'b0 || rd_en0 !== 1'b0 || done0 !== 1'b0) begin failures++; $display("FAIL mid_reset valid=%0b rd_en=%0b done=%0b exp=0/0/0", if0.out_valid, rd_en0, done0); end
    checks++; if (if0.out_addr !== 32'h0 || halt0 !== 1'b0) begin failures++; $display("FAIL mid_reset_run addr=%08h halt=%0b exp=0/0", if0.out_addr, halt0); end
    reset = 1'b1;
    if0.out_ready = 1'b1;
    instr0 = TRAP;
    tick();
    instr0 = '0;
    checks++; if (rd_en0 !== 1'b1 || dmem_addr0 !== 32'h2000) begin failures++; $display("FAIL mid_restart_fetch rd_en=%0b addr=%08h exp=1/00002000", rd_en0, dmem_addr0); end
    tick();
    checks++; if (if0.out_valid !== 1'b1 || if0.out_addr !== 32'h2000 || if0.out_data !== 32'd1) begin failures++; $display("FAIL mid_restart_word valid=%0b addr=%08h data=%08h exp=1/00002000/00000001", if0.out_valid, if0.out_addr, if0.out_data); end
  endtask

  task automatic test_single();
    do_reset();
    if0.out_ready = 1'b1;
    if1.out_ready = 1'b1;
    instr1 = TRAP;
    #1;
    checks++; if (halt1 !== 1'b1) begin failures++; $display("FAIL single_halt got=%0b exp=1", halt1); end
    tick();
    instr1 = '0;
    checks++; if (rd_en1 !== 1'b1 || dmem_addr1 !== 32'h0) begin failures++; $display("FAIL single_fetch rd_en=%0b addr=%08h exp=1/0", rd_en1, dmem_addr1); end
    tick();
    checks++; if (if1.out_valid !== 1'b1 || if1.out_addr !== 32'h0 || if1.out_data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_word valid=%0b addr=%08h data=%08h exp=1/0/deadbeef", if1.out_valid, if1.out_addr, if1.out_data); end
    checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL single_early_done got=%0b exp=0", done1); end
    tick();
    checks++; if (done1 !== 1'b1 || if1.out_valid !== 1'b0 || halt1 !== 1'b1) begin failures++; $display("FAIL single_done done=%0b valid=%0b halt=%0b exp=1/0/1", done1, if1.out_valid, halt1); end
    instr1 = TRAP;
    tick();
    tick();
    instr1 = 32'h12345678;
    tick();
    checks++; if (done1 !== 1'b1 || rd_en1 !== 1'b0 || if1.out_valid !== 1'b0 || halt1 !== 1'b1) begin failures++; $display("FAIL single_terminal done=%0b rd_en=%0b valid=%0b halt=%0b exp=1/0/0/1", done1, rd_en1, if1.out_valid, halt1); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clock    = 1'b0;
    reset    = 1'b0;
    instr0   = '0;
    instr1   = '0;
    if0.out_ready = 1'b0;
    if1.out_ready = 1'b1;
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    for (int k = 0; k < 10; k++) mem[8192 + 4 * k + 3] = 8'(k + 1);
    mem[0] = 8'hDE;
    mem[1] = 8'hAD;
    mem[2] = 8'hBE;
    mem[3] = 8'hEF;

    test_reset();
    test_full_dump();
    test_backpressure();
    test_non_match();
    test_reset_mid();
    test_single();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
